// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM/WB stage: exception cause codes, the
// exception FSM state encoding and default datapath widths.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RN_W_DEF   = 5;

  // ExcCode values written to CP0 Cause for address errors
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic {
    IDLE     = 1'b0,
    EXC_PEND = 1'b1
  } exc_state_e;

endpackage

// File: rtl/pipe_mwreg_exc_capture.sv
// exc_capture: address-error exception FSM for the MEM/WB boundary.
// Captures ExcCode/EPC/BadVAddr on the faulting edge, pulses flush for
// one cycle and holds exc_req until CP0 acknowledges.
module exc_capture
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              err,
  input  logic              exc_ack,
  input  logic              m_store,
  input  logic              m_bd,
  input  logic [DATA_W-1:0] m_pc,
  input  logic [DATA_W-1:0] m_alu,
  output logic              pending,
  output logic              flush,
  output logic              exc_req,
  output logic [4:0]        exc_code,
  output logic [DATA_W-1:0] epc,
  output logic [DATA_W-1:0] badvaddr
);

  exc_state_e        state_q;
  exc_state_e        state_d;
  logic              capture;
  logic              flush_p0;
  logic [4:0]        code_p0;
  logic [DATA_W-1:0] epc_p0;
  logic [DATA_W-1:0] badv_p0;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: an ack in IDLE (even alongside err) is simply dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (err)     state_d = EXC_PEND;
      EXC_PEND: if (exc_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; capture only fires from IDLE
  always_comb begin
    pending = (state_q == EXC_PEND);
    exc_req = (state_q == EXC_PEND);
    capture = (state_q == IDLE) && err;
  end

  // Exception record; EPC backs up to the branch for delay-slot faults
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_p0 <= 1'b0;
      code_p0  <= '0;
      epc_p0   <= '0;
      badv_p0  <= '0;
    end else begin
      flush_p0 <= capture;
      if (capture) begin
        code_p0 <= m_store ? EXC_ADES : EXC_ADEL;
        epc_p0  <= m_bd ? (m_pc - DATA_W'(4)) : m_pc;
        badv_p0 <= m_alu;
      end
    end
  end

  assign flush    = flush_p0;
  assign exc_code = code_p0;
  assign epc      = epc_p0;
  assign badvaddr = badv_p0;

endmodule

// File: rtl/pipe_mwreg.sv
// pipe_mwreg: MEM/WB stage register with precise address-error exceptions.
// Optional build macro PIPE_MWREG_PERF_EN adds retired/exception counters.
module pipe_mwreg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RN_W   = RN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              m_valid,
  input  logic              m_wreg,
  input  logic              m_m2reg,
  input  logic              m_load,
  input  logic              m_store,
  input  logic              m_bd,
  input  logic [RN_W-1:0]   m_rn,
  input  logic [DATA_W-1:0] m_alu,
  input  logic [DATA_W-1:0] m_mem,
  input  logic [DATA_W-1:0] m_pc,
  input  logic              m_addr_err,
  input  logic              exc_ack,
  output logic              w_valid,
  output logic              w_wreg,
  output logic [RN_W-1:0]   w_rn,
  output logic [DATA_W-1:0] w_wdata,
  output logic              flush,
  output logic              exc_req,
  output logic [4:0]        exc_code,
  output logic [DATA_W-1:0] epc,
  output logic [DATA_W-1:0] badvaddr
`ifdef PIPE_MWREG_PERF_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       exc_cnt
`endif
);

  logic              err;
  logic              pending;
  logic              vld_p0;
  logic              wreg_p0;
  logic [RN_W-1:0]   rn_p0;
  logic [DATA_W-1:0] wdata_p0;

  // A stalled MEM instruction is re-presented later, so it cannot fault yet
  assign err = m_valid & m_addr_err & (m_load | m_store) & ~stall;

  exc_capture #(
    .DATA_W(DATA_W)
  ) u_exc (
    .clk      (clk),
    .rst      (rst),
    .err      (err),
    .exc_ack  (exc_ack),
    .m_store  (m_store),
    .m_bd     (m_bd),
    .m_pc     (m_pc),
    .m_alu    (m_alu),
    .pending  (pending),
    .flush    (flush),
    .exc_req  (exc_req),
    .exc_code (exc_code),
    .epc      (epc),
    .badvaddr (badvaddr)
  );

  // MEM -> WB boundary: faulting or killed instructions never write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      wreg_p0  <= 1'b0;
      rn_p0    <= '0;
      wdata_p0 <= '0;
    end else if (pending || err) begin
      vld_p0  <= 1'b0;
      wreg_p0 <= 1'b0;
    end else if (!stall) begin
      vld_p0   <= m_valid;
      wreg_p0  <= m_valid & m_wreg;
      rn_p0    <= m_rn;
      wdata_p0 <= m_m2reg ? m_mem : m_alu;
    end
  end

  assign w_valid = vld_p0;
  assign w_wreg  = wreg_p0;
  assign w_rn    = rn_p0;
  assign w_wdata = wdata_p0;

`ifdef PIPE_MWREG_PERF_EN
  // Event counters: retirements into WB and exception entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      exc_cnt     <= '0;
    end else begin
      if (!pending && !err && !stall && m_valid) retired_cnt <= retired_cnt + 32'd1;
      if (!pending && err)                       exc_cnt     <= exc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mwreg.sv
// Bench for pipe_mwreg: directed steps, expected outputs queued when the
// stimulus is driven and checked after the following clock edge.
module tb_pipe_mwreg;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, m_valid, m_wreg, m_m2reg, m_load, m_store, m_bd;
  logic [4:0]  m_rn;
  logic [31:0] m_alu, m_mem, m_pc;
  logic        m_addr_err, exc_ack;
  logic        w_valid, w_wreg, flush, exc_req;
  logic [4:0]  w_rn, exc_code;
  logic [31:0] w_wdata, epc, badvaddr;
`ifdef PIPE_MWREG_PERF_EN
  logic [31:0] retired_cnt, exc_cnt;
`endif

  pipe_mwreg dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .m_valid    (m_valid),
    .m_wreg     (m_wreg),
    .m_m2reg    (m_m2reg),
    .m_load     (m_load),
    .m_store    (m_store),
    .m_bd       (m_bd),
    .m_rn       (m_rn),
    .m_alu      (m_alu),
    .m_mem      (m_mem),
    .m_pc       (m_pc),
    .m_addr_err (m_addr_err),
    .exc_ack    (exc_ack),
    .w_valid    (w_valid),
    .w_wreg     (w_wreg),
    .w_rn       (w_rn),
    .w_wdata    (w_wdata),
    .flush      (flush),
    .exc_req    (exc_req),
    .exc_code   (exc_code),
    .epc        (epc),
    .badvaddr   (badvaddr)
`ifdef PIPE_MWREG_PERF_EN
    ,
    .retired_cnt(retired_cnt),
    .exc_cnt    (exc_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        wreg;
    logic [4:0]  rn;
    logic [31:0] wdata;
    logic        flush;
    logic        req;
    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] badv;
    bit          chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic v, input logic wr, input logic [4:0] rn,
                              input logic [31:0] wd, input logic fl, input logic rq,
                              input logic [4:0] cd, input logic [31:0] ep,
                              input logic [31:0] bv, input bit cdat);
    exp_t e;
    e.valid = v; e.wreg = wr; e.rn = rn; e.wdata = wd; e.flush = fl;
    e.req = rq; e.code = cd; e.epc = ep; e.badv = bv; e.chk_data = cdat;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp({tag, ".w_valid"},  {31'd0, w_valid}, {31'd0, e.valid});
      cmp({tag, ".w_wreg"},   {31'd0, w_wreg},  {31'd0, e.wreg});
      cmp({tag, ".flush"},    {31'd0, flush},   {31'd0, e.flush});
      cmp({tag, ".exc_req"},  {31'd0, exc_req}, {31'd0, e.req});
      cmp({tag, ".exc_code"}, {27'd0, exc_code}, {27'd0, e.code});
      cmp({tag, ".epc"},      epc,      e.epc);
      cmp({tag, ".badvaddr"}, badvaddr, e.badv);
      if (e.chk_data) begin
        cmp({tag, ".w_rn"},    {27'd0, w_rn}, {27'd0, e.rn});
        cmp({tag, ".w_wdata"}, w_wdata, e.wdata);
      end
    end
  endtask

  task automatic idle_in();
    stall = 1'b0; m_valid = 1'b0; m_wreg = 1'b0; m_m2reg = 1'b0;
    m_load = 1'b0; m_store = 1'b0; m_bd = 1'b0; m_rn = '0;
    m_alu = '0; m_mem = '0; m_pc = '0; m_addr_err = 1'b0; exc_ack = 1'b0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    // reset with random inputs
    rst = 1'b1;
    stall = 1'($urandom); m_valid = 1'($urandom); m_wreg = 1'($urandom);
    m_m2reg = 1'($urandom); m_load = 1'($urandom); m_store = 1'($urandom);
    m_bd = 1'($urandom); m_rn = 5'($urandom); m_alu = $urandom; m_mem = $urandom;
    m_pc = $urandom; m_addr_err = 1'($urandom); exc_ack = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 32'h0, 1));
    check_out("reset");

    idle_in();
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 32'h0, 1));
    step("release");

    // normal load, then ALU result
    m_valid = 1; m_wreg = 1; m_m2reg = 1; m_rn = 5'd8; m_mem = 32'hFFFF_FF80; m_alu = 32'h100;
    exp_q.push_back(mk(1, 1, 5'd8, 32'hFFFF_FF80, 0, 0, 5'd0, 32'h0, 32'h0, 1));
    step("load_mem");
    m_m2reg = 0;
    exp_q.push_back(mk(1, 1, 5'd8, 32'h100, 0, 0, 5'd0, 32'h0, 32'h0, 1));
    step("load_alu");

    // stall holds the W register and suppresses error detection
    m_rn = 5'd3; m_alu = 32'hA;
    exp_q.push_back(mk(1, 1, 5'd3, 32'hA, 0, 0, 5'd0, 32'h0, 32'h0, 1));
    step("pre_stall");
    stall = 1; m_load = 1; m_addr_err = 1;
    for (int i = 0; i < 3; i++) begin
      m_alu = 32'h200 + 32'(i);
      exp_q.push_back(mk(1, 1, 5'd3, 32'hA, 0, 0, 5'd0, 32'h0, 32'h0, 1));
      step("stall");
    end

    // store address error in a delay slot
    idle_in();
    m_valid = 1; m_wreg = 1; m_store = 1; m_bd = 1; m_rn = 5'd9;
    m_pc = 32'h0040_0010; m_alu = 32'h1001; m_addr_err = 1;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 1, 1, 5'd5, 32'h0040_000C, 32'h1001, 0));
    step("ades");
    idle_in();
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 0, 1, 5'd5, 32'h0040_000C, 32'h1001, 0));
    step("ades_hold");
    exc_ack = 1;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 0, 0, 5'd5, 32'h0040_000C, 32'h1001, 0));
    step("ades_ack");

    // load address error at PC 0, not in a delay slot
    idle_in();
    m_valid = 1; m_wreg = 1; m_load = 1; m_pc = 32'h0; m_alu = 32'h2; m_addr_err = 1;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 1, 1, 5'd4, 32'h0, 32'h2, 0));
    step("adel");
    m_load = 0; m_store = 1; m_bd = 1; m_pc = 32'h100; m_alu = 32'h333;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 0, 1, 5'd4, 32'h0, 32'h2, 0));
    step("second_err");
    idle_in();
    m_valid = 1; m_wreg = 1; m_load = 1; m_m2reg = 1; m_rn = 5'd7; m_mem = 32'h55;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 0, 1, 5'd4, 32'h0, 32'h2, 0));
    step("killed_load");
    stall = 1; exc_ack = 1;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 0, 0, 5'd4, 32'h0, 32'h2, 0));
    step("ack_under_stall");
    stall = 0; exc_ack = 0;
    exp_q.push_back(mk(1, 1, 5'd7, 32'h55, 0, 0, 5'd4, 32'h0, 32'h2, 1));
    step("load_after_ack");

    // ack in IDLE is ignored
    idle_in();
    m_valid = 1; m_wreg = 1; m_rn = 5'd2; m_alu = 32'h77; exc_ack = 1;
    exp_q.push_back(mk(1, 1, 5'd2, 32'h77, 0, 0, 5'd4, 32'h0, 32'h2, 1));
    step("idle_ack");

    // load+store both set: store wins; EPC wraps; simultaneous ack discarded
    idle_in();
    m_valid = 1; m_wreg = 1; m_load = 1; m_store = 1; m_bd = 1;
    m_pc = 32'h0; m_alu = 32'h3; m_addr_err = 1; exc_ack = 1;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 1, 1, 5'd5, 32'hFFFF_FFFC, 32'h3, 0));
    step("both_wrap");
    idle_in();
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 0, 1, 5'd5, 32'hFFFF_FFFC, 32'h3, 0));
    step("ack_discarded");
    exc_ack = 1;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 0, 0, 5'd5, 32'hFFFF_FFFC, 32'h3, 0));
    step("ack2");

    // async reset while the flush pulse and request are up
    idle_in();
    m_valid = 1; m_load = 1; m_pc = 32'h80; m_alu = 32'h81; m_addr_err = 1;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 1, 1, 5'd4, 32'h80, 32'h81, 0));
    step("adel_pre_rst");
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 32'h0, 1));
    check_out("async_rst");
    idle_in();
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(mk(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 32'h0, 1));
    step("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
